// File: rtl/imm_gen_stage.sv
// Two-stage pipelined RV64I immediate generator: stage 1 captures the instruction and its format,
// stage 2 assembles the sign-extended 64-bit immediate. Valid/ready on both sides, flush, illegal counter.
module imm_gen_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        inValid,
    output logic        inReady,
    input  logic [31:0] instr,
    input  logic        flush,
    output logic        outValid,
    input  logic        outReady,
    output logic [63:0] immOut,
    output logic [2:0]  fmtOut,
    output logic        illegalOut,
    output logic [15:0] illegalCount
);

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_SH  = 3'd6,
        FMT_ILL = 3'd7
    } fmt_e;

    logic        v1_q;
    logic [31:7] instrS1_q;
    logic        shWord_q;
    fmt_e        fmtS1_q;

    logic        v2_q;
    logic [63:0] imm_q;
    fmt_e        fmt_q;
    logic        ill_q;

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    fmt_e        fmtDec;
    logic [63:0] immAsm;
    logic        loadS1;
    logic        loadS2;
    logic        outHs;

    // Stage 1 accepts whenever stage 2 can drain it this cycle or it is already empty.
    assign loadS2  = !v2_q || outReady;
    assign inReady = !reset && !flush && (!v1_q || !v2_q || outReady);
    assign loadS1  = inReady && inValid;
    assign outHs   = v2_q && outReady;

    always_comb begin
        fmtDec = FMT_ILL;
        case (instr[6:0])
            7'b0000011,
            7'b1100111: fmtDec = FMT_I;
            // funct3 001/101 (bits [13:12] == 01) selects the shift-immediate forms
            7'b0010011,
            7'b0011011: fmtDec = (instr[13:12] == 2'b01) ? FMT_SH : FMT_I;
            7'b0100011: fmtDec = FMT_S;
            7'b1100011: fmtDec = FMT_B;
            7'b0110111,
            7'b0010111: fmtDec = FMT_U;
            7'b1101111: fmtDec = FMT_J;
            7'b0110011,
            7'b0111011: fmtDec = FMT_R;
            default:    fmtDec = FMT_ILL;
        endcase
    end

    always_comb begin
        immAsm = 64'd0;
        case (fmtS1_q)
            FMT_I:  immAsm = {{52{instrS1_q[31]}}, instrS1_q[31:20]};
            FMT_SH: immAsm = shWord_q ? {59'd0, instrS1_q[24:20]}
                                      : {58'd0, instrS1_q[25:20]};
            FMT_S:  immAsm = {{52{instrS1_q[31]}}, instrS1_q[31:25], instrS1_q[11:7]};
            FMT_B:  immAsm = {{51{instrS1_q[31]}}, instrS1_q[31], instrS1_q[7],
                              instrS1_q[30:25], instrS1_q[11:8], 1'b0};
            FMT_U:  immAsm = {{32{instrS1_q[31]}}, instrS1_q[31:12], 12'd0};
            FMT_J:  immAsm = {{43{instrS1_q[31]}}, instrS1_q[31], instrS1_q[19:12],
                              instrS1_q[20], instrS1_q[30:21], 1'b0};
            default: immAsm = 64'd0;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (outHs && ill_q && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Valid bits honour flush first; data registers only move on an actual load so stalls hold bit-for-bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1_q      <= 1'b0;
            instrS1_q <= '0;
            shWord_q  <= 1'b0;
            fmtS1_q   <= FMT_R;
            v2_q      <= 1'b0;
            imm_q     <= 64'd0;
            fmt_q     <= FMT_R;
            ill_q     <= 1'b0;
            cnt_q     <= 16'd0;
        end else begin
            if (flush) begin
                v1_q <= 1'b0;
                v2_q <= 1'b0;
            end else begin
                if (inReady) begin
                    v1_q <= inValid;
                end
                if (loadS2) begin
                    v2_q <= v1_q;
                end
            end
            if (loadS1) begin
                instrS1_q <= instr[31:7];
                shWord_q  <= instr[3];
                fmtS1_q   <= fmtDec;
            end
            if (!flush && loadS2 && v1_q) begin
                imm_q <= immAsm;
                fmt_q <= fmtS1_q;
                ill_q <= (fmtS1_q == FMT_ILL);
            end
            cnt_q <= cnt_d;
        end
    end

    assign outValid     = v2_q;
    assign immOut       = imm_q;
    assign fmtOut       = fmt_q;
    assign illegalOut   = ill_q;
    assign illegalCount = cnt_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Testbench for imm_gen_stage: directed test-plan vectors followed by randomized traffic
// scored against an arithmetic reference model and an in-order expectation queue.
module tb_imm_gen_stage;

    logic        clk;
    logic        reset;
    logic        inValid;
    logic        inReady;
    logic [31:0] instr;
    logic        flush;
    logic        outValid;
    logic        outReady;
    logic [63:0] immOut;
    logic [2:0]  fmtOut;
    logic        illegalOut;
    logic [15:0] illegalCount;

    int compared;
    int mismatched;

    typedef struct packed {
        logic [63:0] imm;
        logic [2:0]  fmt;
    } exp_t;

    exp_t sb[$];
    int   cntModel;

    imm_gen_stage dut (
        .clk          (clk),
        .reset        (reset),
        .inValid      (inValid),
        .inReady      (inReady),
        .instr        (instr),
        .flush        (flush),
        .outValid     (outValid),
        .outReady     (outReady),
        .immOut       (immOut),
        .fmtOut       (fmtOut),
        .illegalOut   (illegalOut),
        .illegalCount (illegalCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sign-extend the low 'bits' bits of v using plain arithmetic.
    function automatic longint sext(input longint v, input int bits);
        longint half;
        longint full;
        half = longint'(1) << (bits - 1);
        full = longint'(1) << bits;
        return (v >= half) ? v - full : v;
    endfunction

    function automatic exp_t refModel(input logic [31:0] w);
        exp_t   r;
        longint x;
        int     op;
        int     f3;
        x  = longint'(w);
        op = int'(w[6:0]);
        f3 = int'(w[14:12]);
        r.imm = 64'd0;
        r.fmt = 3'd7;
        if (op == 'h13 && (f3 == 1 || f3 == 5)) begin
            r.fmt = 3'd6;
            r.imm = 64'((x >> 20) % 64);
        end else if (op == 'h1B && (f3 == 1 || f3 == 5)) begin
            r.fmt = 3'd6;
            r.imm = 64'((x >> 20) % 32);
        end else if (op == 'h03 || op == 'h13 || op == 'h1B || op == 'h67) begin
            r.fmt = 3'd1;
            r.imm = 64'(sext(x >> 20, 12));
        end else if (op == 'h23) begin
            r.fmt = 3'd2;
            r.imm = 64'(sext((x >> 25) * 32 + (x >> 7) % 32, 12));
        end else if (op == 'h63) begin
            r.fmt = 3'd3;
            r.imm = 64'(sext((x >> 31) * 4096 + ((x >> 7) % 2) * 2048
                             + ((x >> 25) % 64) * 32 + ((x >> 8) % 16) * 2, 13));
        end else if (op == 'h37 || op == 'h17) begin
            r.fmt = 3'd4;
            r.imm = 64'(sext((x >> 12) * 4096, 32));
        end else if (op == 'h6F) begin
            r.fmt = 3'd5;
            r.imm = 64'(sext((x >> 31) * 1048576 + ((x >> 12) % 256) * 4096
                             + ((x >> 20) % 2) * 2048 + ((x >> 21) % 1024) * 2, 21));
        end else if (op == 'h33 || op == 'h3B) begin
            r.fmt = 3'd0;
            r.imm = 64'd0;
        end
        return r;
    endfunction

    // One scored cycle: drive inputs, retire any output handshake against the queue, then clock.
    task automatic applyStimulus(input logic iv, input logic [31:0] w, input logic ordy, input logic fl);
        logic        inHs;
        logic        outHs;
        logic        holding;
        logic [63:0] heldImm;
        logic [2:0]  heldFmt;
        exp_t        e;
        inValid  = iv;
        instr    = w;
        outReady = ordy;
        flush    = fl;
        #1;
        inHs    = inValid && inReady;
        outHs   = outValid && outReady;
        holding = outValid && !outReady && !flush;
        heldImm = immOut;
        heldFmt = fmtOut;
        if (outHs) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_output", 64'(outValid), 64'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("rnd_imm", immOut, e.imm);
                checkOutput("rnd_fmt", 64'(fmtOut), 64'(e.fmt));
                checkOutput("rnd_ill", 64'(illegalOut), 64'(e.fmt == 3'd7));
                if (e.fmt == 3'd7 && cntModel < 65535) cntModel++;
            end
        end
        tick();
        if (fl) sb.delete();
        else if (inHs) sb.push_back(refModel(w));
        if (holding) begin
            checkOutput("hold_valid", 64'(outValid), 64'd1);
            checkOutput("hold_imm", immOut, heldImm);
            checkOutput("hold_fmt", 64'(fmtOut), 64'(heldFmt));
        end
        checkOutput("rnd_count", 64'(illegalCount), 64'(cntModel));
    endtask

    logic [6:0] opTable [12];
    logic [31:0] w;

    initial begin
        compared   = 0;
        mismatched = 0;
        cntModel   = 0;
        opTable = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h23, 7'h63,
                    7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B, 7'h00};
        reset    = 1'b0;
        inValid  = 1'b0;
        instr    = 32'd0;
        flush    = 1'b0;
        outReady = 1'b0;

        // Reset values
        #1 reset = 1'b1;
        #1;
        checkOutput("rst_outValid", 64'(outValid), 64'd0);
        checkOutput("rst_immOut", immOut, 64'd0);
        checkOutput("rst_fmtOut", 64'(fmtOut), 64'd0);
        checkOutput("rst_illegal", 64'(illegalOut), 64'd0);
        checkOutput("rst_count", 64'(illegalCount), 64'd0);
        checkOutput("rst_inReady", 64'(inReady), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        checkOutput("post_rst_inReady", 64'(inReady), 64'd1);

        // addi with two-cycle latency
        inValid = 1'b1; instr = 32'hFFF00093; outReady = 1'b1;
        tick();
        inValid = 1'b0;
        checkOutput("addi_lat1_valid", 64'(outValid), 64'd0);
        tick();
        checkOutput("addi_valid", 64'(outValid), 64'd1);
        checkOutput("addi_imm", immOut, 64'hFFFFFFFFFFFFFFFF);
        checkOutput("addi_fmt", 64'(fmtOut), 64'd1);
        tick();
        checkOutput("addi_drained", 64'(outValid), 64'd0);

        // Back-to-back sw, lui, jal
        inValid = 1'b1; instr = 32'hFE20AE23;
        tick();
        instr = 32'h800002B7;
        tick();
        checkOutput("sw_imm", immOut, 64'hFFFFFFFFFFFFFFFC);
        checkOutput("sw_fmt", 64'(fmtOut), 64'd2);
        instr = 32'h001000EF;
        tick();
        inValid = 1'b0;
        checkOutput("lui_imm", immOut, 64'hFFFFFFFF80000000);
        checkOutput("lui_fmt", 64'(fmtOut), 64'd4);
        tick();
        checkOutput("jal_valid", 64'(outValid), 64'd1);
        checkOutput("jal_imm", immOut, 64'h0000000000000800);
        checkOutput("jal_fmt", 64'(fmtOut), 64'd5);
        tick();

        // slli shift immediate
        inValid = 1'b1; instr = 32'h03F09093;
        tick();
        inValid = 1'b0;
        tick();
        checkOutput("slli_imm", immOut, 64'h000000000000003F);
        checkOutput("slli_fmt", 64'(fmtOut), 64'd6);
        tick();

        // Backpressure with A, B, C
        outReady = 1'b0;
        inValid = 1'b1; instr = 32'h00500093;
        #1 checkOutput("bp_rdyA", 64'(inReady), 64'd1);
        tick();
        instr = 32'h00A00113;
        #1 checkOutput("bp_rdyB", 64'(inReady), 64'd1);
        tick();
        instr = 32'hFFF00093;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("bp_full_rdy", 64'(inReady), 64'd0);
            checkOutput("bp_stable_valid", 64'(outValid), 64'd1);
            checkOutput("bp_stable_imm", immOut, 64'd5);
            tick();
        end
        outReady = 1'b1;
        #1 checkOutput("bp_comb_rdy", 64'(inReady), 64'd1);
        tick();
        inValid = 1'b0;
        checkOutput("bp_B_imm", immOut, 64'd10);
        tick();
        checkOutput("bp_C_imm", immOut, 64'hFFFFFFFFFFFFFFFF);
        tick();
        checkOutput("bp_empty", 64'(outValid), 64'd0);

        // Flush with both stages full
        outReady = 1'b0;
        inValid = 1'b1; instr = 32'h00100093;
        tick();
        instr = 32'h00200093;
        tick();
        flush = 1'b1; instr = 32'h00300093;
        #1 checkOutput("flush_rdy", 64'(inReady), 64'd0);
        tick();
        flush = 1'b0; inValid = 1'b0;
        checkOutput("flush_valid", 64'(outValid), 64'd0);
        tick();
        checkOutput("flush_not_accepted", 64'(outValid), 64'd0);
        outReady = 1'b1; inValid = 1'b1; instr = 32'h00000000;
        tick();
        inValid = 1'b0;
        tick();
        checkOutput("ill_fmt", 64'(fmtOut), 64'd7);
        checkOutput("ill_flag", 64'(illegalOut), 64'd1);
        checkOutput("ill_imm", immOut, 64'd0);
        checkOutput("ill_count_pre", 64'(illegalCount), 64'd0);
        tick();
        checkOutput("ill_count_post", 64'(illegalCount), 64'd1);

        // Flush coinciding with an illegal output handshake
        outReady = 1'b0; inValid = 1'b1; instr = 32'h0000007F;
        tick();
        instr = 32'h00000000;
        tick();
        inValid = 1'b0; flush = 1'b1; outReady = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("flushhs_count", 64'(illegalCount), 64'd2);
        checkOutput("flushhs_valid", 64'(outValid), 64'd0);
        tick();
        checkOutput("flushhs_empty", 64'(outValid), 64'd0);

        // Reset while output is valid
        outReady = 1'b0; inValid = 1'b1; instr = 32'h12345037;
        tick();
        inValid = 1'b0;
        tick();
        checkOutput("midrst_pre_valid", 64'(outValid), 64'd1);
        reset = 1'b1;
        #1;
        checkOutput("midrst_valid", 64'(outValid), 64'd0);
        checkOutput("midrst_imm", immOut, 64'd0);
        checkOutput("midrst_count", 64'(illegalCount), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        #1 checkOutput("midrst_rdy", 64'(inReady), 64'd1);
        outReady = 1'b1; inValid = 1'b1; instr = 32'h7FF00093;
        tick();
        inValid = 1'b0;
        checkOutput("midrst_lat1", 64'(outValid), 64'd0);
        tick();
        checkOutput("midrst_lat2_valid", 64'(outValid), 64'd1);
        checkOutput("midrst_lat2_imm", immOut, 64'h00000000000007FF);
        tick();

        // Randomized traffic against the reference model
        cntModel = 0;
        sb.delete();
        for (int i = 0; i < 400; i++) begin
            w = $urandom();
            w[6:0] = opTable[$urandom_range(0, 11)];
            if ($urandom_range(0, 9) == 0) w[6:0] = 7'($urandom());
            applyStimulus(1'($urandom_range(0, 1)), w,
                          ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        end
        checkOutput("drain_queue", 64'(sb.size()), 64'd0);
        checkOutput("drain_valid", 64'(outValid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
